verilab_i2c_target_rx: RTL and testbench
========================================

# verilab_i2c_target_rx

Write-only I2C target receiver sitting directly downstream of the pad ring. It consumes the core-side I2C pad signals (`core_i2c_scl_in`/`core_i2c_sda_in`) and drives the pad enables (`core_i2c_*_out/en`). It detects START/STOP, matches a 7-bit address, ACKs, and delivers received data bytes on a valid/ready stream to the core register logic.

## Interface
- `FILTER_LEN`, default 3: consecutive identical synchronized samples required before a filtered line changes (1..15).
- `TARGET_ADDR`, default 7'h42: 7-bit target address.
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `core_i2c_scl_in` input 1: SCL from pad, asynchronous.
- `core_i2c_sda_in` input 1: SDA from pad, asynchronous.
- `core_i2c_scl_out` output 1: tied 0.
- `core_i2c_scl_en` output 1: pulls SCL low (clock stretch).
- `core_i2c_sda_out` output 1: tied 0.
- `core_i2c_sda_en` output 1: pulls SDA low (ACK).
- `rx_data` output 8: received byte.
- `rx_first` output 1: `rx_data` is the first byte after the address.
- `rx_valid` output 1: byte available.
- `rx_ready` input 1: consumer accepts the byte.
- `start_det` output 1: one-cycle pulse on START or repeated START.
- `stop_det` output 1: one-cycle pulse on STOP.
- `overflow` output 1: one-cycle pulse when a byte is dropped.

## Operation
- Each line passes through a 2-flop synchronizer, then a filter. The filtered value copies the synced value only after `FILTER_LEN` consecutive equal samples.
- Events are taken from the filtered lines:
  - scl_rise and scl_fall are SCL edges.
  - START is an SDA fall while SCL is high.
  - STOP is an SDA rise while SCL is high.
- State machine states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE, plus STRETCH when configured.
- START from any state:
  - Go to ADDR and clear the 3-bit bit counter.
  - Release `sda_en` and `scl_en` in the same cycle.
  - Pulse `start_det`.
- STOP from any state: go to IDLE, release both enables, pulse `stop_det`.
- ADDR and DATA shift SDA in MSB first on each scl_rise. The counter wraps 7→0; the 8th rise completes the byte.
- Address byte:
  - If `[7:1]==TARGET_ADDR` and `[0]==0` (write), go to ADDR_ACK.
  - Otherwise go to IGNORE and never drive SDA.
  - IGNORE is left only by START or STOP.
- ADDR_ACK: assert `sda_en` from the next scl_fall until the following scl_fall, then go to DATA. Set the first-byte flag.
- DATA, at the scl_fall after the 8th rise:
  - Buffer free (`rx_valid==0`, or `rx_valid&&rx_ready` this cycle): load `rx_data`/`rx_first`, set `rx_valid`, ACK for one SCL low-high-low, clear the first-byte flag.
  - Buffer full: NACK (SDA not driven), drop the byte, pulse `overflow`.
  - Either way, return to DATA after the ACK slot.
- `rx_valid` clears on `rx_valid&&rx_ready`. `rx_data` and `rx_first` stay stable while valid.
- Bytes still in flight when STOP arrives are discarded. A byte already in the buffer stays valid.

## Timing
- Reset values:
  - All outputs 0.
  - Filtered lines 1, synchronizer flops 1.
  - State IDLE, counter 0.
- Pad edge to internal event: 2 + `FILTER_LEN` clk.
- `start_det`/`stop_det` assert in the event cycle.
- `sda_en`, `rx_valid` and `overflow` are registered and assert 1 clk after the scl_fall event cycle.
- `sda_en` deasserts 1 clk after the scl_fall that ends the ACK slot.
- START/STOP override any ACK or stretch in progress; enables drop 1 clk later.
- Reset asserted mid-transfer returns to reset values on the next edge, even with SCL/SDA low.

## Configuration
- `VERILAB_I2C_STRETCH_EN` defined:
  - On a full buffer at the DATA ACK point, enter STRETCH and assert `scl_en` (1 clk after scl_fall).
  - Hold it until the buffer frees, then load the byte, assert `sda_en`, and drop `scl_en` on the next cycle.
  - `overflow` never pulses.
- Undefined: NACK/drop behaviour as above; `scl_en` is a constant 0 and there is no STRETCH state.

## Structure
- Package `verilab_i2c_pkg` holds the state enum `i2c_rx_state_e`, `I2C_ADDR_W=7`, and `I2C_BYTE_W=8`.
- Sub-module `verilab_i2c_line_filter` (synchronizer plus filter, parameter `FILTER_LEN`, reset value 1) is instantiated once per line.

## Test plan
- Write START, 0x84, 0xA5, 0x3C, STOP with `rx_ready=1` → ACK on all three bytes. `rx_data` is 0xA5 with `rx_first=1`, then 0x3C with `rx_first=0`. One `start_det` and one `stop_det`.
- Address 0x86 (wrong address), and 0x85 (read) → SDA never driven, no `rx_valid`, IGNORE held until STOP.
- `rx_ready=0`, write 0x11 then 0x22 → 0x11 is held. Without the macro: NACK on 0x22 and one `overflow` pulse. With the macro: SCL held low until `rx_ready` rises, then 0x22 is ACKed.
- Repeated START after the first data byte, then 0x84, 0x77 → 0x77 arrives with `rx_first=1`.
- SCL glitch shorter than `FILTER_LEN` clk during a data bit → no extra bit shifted, byte correct.
- Reset asserted during an ACK slot → `sda_en` is 0 on the next cycle, state IDLE, and no `rx_valid`.

Source files
------------

// File: rtl/verilab_i2c_pkg.sv
// -----------------------------------------------------------------------------
// verilab_i2c_pkg
// Shared types and constants for the write-only I2C target receiver.
// Optional feature macro: VERILAB_I2C_STRETCH_EN adds the STRETCH state.
// -----------------------------------------------------------------------------
package verilab_i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
`ifdef VERILAB_I2C_STRETCH_EN
    ,ST_STRETCH = 3'd6
`endif
  } i2c_rx_state_e;

  // Address byte selects us only for a write to our 7-bit address.
  function automatic logic addr_is_write_to(input logic [I2C_BYTE_W-1:0] addr_byte,
                                            input logic [I2C_ADDR_W-1:0] target);
    return (addr_byte[I2C_BYTE_W-1:1] == target) && !addr_byte[0];
  endfunction

endpackage

// File: rtl/verilab_i2c_target_rx_line_filter.sv
// -----------------------------------------------------------------------------
// verilab_i2c_line_filter
// 2-flop synchronizer followed by a glitch filter for one I2C line. The
// filtered output only follows the synchronized value once it has been seen
// FILTER_LEN consecutive cycles. Everything resets to 1 (bus idle level).
// Ports:
//   clk      - system clock
//   reset    - synchronous active-high reset
//   line_in  - asynchronous pad input
//   line_out - synchronized, filtered line
// -----------------------------------------------------------------------------
module verilab_i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_out
);

  logic       sync1_q, sync2_q;
  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;

  // cnt_q counts how many consecutive samples have differed from filt_q.
  always_comb begin
    cnt_d  = 4'd0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == 4'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= 4'd0;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign line_out = filt_q;

endmodule

// File: rtl/verilab_i2c_target_rx.sv
// -----------------------------------------------------------------------------
// verilab_i2c_target_rx
// Write-only I2C target: detects START/STOP, matches TARGET_ADDR (write only),
// ACKs, and hands data bytes to the core on a valid/ready stream.
// Optional feature macro: VERILAB_I2C_STRETCH_EN - stretch SCL instead of
// NACKing when the output buffer is still full.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   core_i2c_scl_in/sda_in     - asynchronous pad inputs
//   core_i2c_scl_out/sda_out   - tied 0 (open drain)
//   core_i2c_scl_en            - pull SCL low (stretch)
//   core_i2c_sda_en            - pull SDA low (ACK)
//   rx_data/rx_first/rx_valid  - received byte stream, rx_ready from consumer
//   start_det/stop_det         - bus event pulses
//   overflow                   - byte dropped pulse
// -----------------------------------------------------------------------------
module verilab_i2c_target_rx
  import verilab_i2c_pkg::*;
#(
  parameter int                    FILTER_LEN  = 3,
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h42
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_i2c_scl_in,
  input  logic                  core_i2c_sda_in,
  output logic                  core_i2c_scl_out,
  output logic                  core_i2c_scl_en,
  output logic                  core_i2c_sda_out,
  output logic                  core_i2c_sda_en,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_first,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  start_det,
  output logic                  stop_det,
  output logic                  overflow
);

  logic scl_f, sda_f;

  verilab_i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .reset(reset), .line_in(core_i2c_scl_in), .line_out(scl_f));
  verilab_i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .reset(reset), .line_in(core_i2c_sda_in), .line_out(sda_f));

  i2c_rx_state_e         state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic                  byte_done_q, byte_done_d;  // 8th rise seen in DATA
  logic                  ack_drive_q, ack_drive_d;  // address ACK slot active
  logic                  first_q, first_d;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_first_q, rx_first_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  sda_en_q, sda_en_d;
  logic                  overflow_q, overflow_d;
  logic                  scl_prev_q, sda_prev_q;
`ifdef VERILAB_I2C_STRETCH_EN
  logic                  scl_en_q, scl_en_d;
`endif

  logic                  scl_rise, scl_fall, start_ev, stop_ev, buf_free;
  logic [I2C_BYTE_W-1:0] byte_in;

  assign scl_rise = scl_f & ~scl_prev_q;
  assign scl_fall = ~scl_f & scl_prev_q;
  assign start_ev = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_ev  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
  assign byte_in  = {shift_q[I2C_BYTE_W-2:0], sda_f};
  // Free if empty, or the consumer is taking the current byte this cycle.
  assign buf_free = ~rx_valid_q | rx_ready;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done_d = byte_done_q;
    ack_drive_d = ack_drive_q;
    first_d     = first_q;
    rx_data_d   = rx_data_q;
    rx_first_d  = rx_first_q;
    rx_valid_d  = rx_valid_q & ~rx_ready;
    sda_en_d    = sda_en_q;
    overflow_d  = 1'b0;
`ifdef VERILAB_I2C_STRETCH_EN
    scl_en_d    = scl_en_q;
`endif

    case (state_q)
      ST_ADDR: begin
        if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ack_drive_d = 1'b0;
            state_d = addr_is_write_to(byte_in, TARGET_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
          end
        end
      end
      ST_ADDR_ACK: begin
        if (scl_fall) begin
          if (!ack_drive_q) begin
            sda_en_d    = 1'b1;
            ack_drive_d = 1'b1;
          end else begin
            sda_en_d    = 1'b0;
            ack_drive_d = 1'b0;
            first_d     = 1'b1;
            state_d     = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
        end else if (scl_fall && byte_done_q) begin
          byte_done_d = 1'b0;
          if (buf_free) begin
            rx_data_d  = shift_q;
            rx_first_d = first_q;
            rx_valid_d = 1'b1;
            sda_en_d   = 1'b1;
            first_d    = 1'b0;
            state_d    = ST_DATA_ACK;
          end else begin
`ifdef VERILAB_I2C_STRETCH_EN
            scl_en_d   = 1'b1;
            state_d    = ST_STRETCH;
`else
            overflow_d = 1'b1;
            state_d    = ST_DATA_ACK;
`endif
          end
        end
      end
      ST_DATA_ACK: begin
        if (scl_fall) begin
          sda_en_d = 1'b0;
          state_d  = ST_DATA;
        end
      end
`ifdef VERILAB_I2C_STRETCH_EN
      ST_STRETCH: begin
        if (buf_free) begin
          rx_data_d  = shift_q;
          rx_first_d = first_q;
          rx_valid_d = 1'b1;
          sda_en_d   = 1'b1;
          first_d    = 1'b0;
          scl_en_d   = 1'b0;
          state_d    = ST_DATA_ACK;
        end
      end
`endif
      ST_IDLE, ST_IGNORE: ;
      default: state_d = ST_IDLE;
    endcase

    // Bus conditions override whatever the byte/ACK logic decided.
    if (start_ev || stop_ev) begin
      state_d     = start_ev ? ST_ADDR : ST_IDLE;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      ack_drive_d = 1'b0;
      sda_en_d    = 1'b0;
`ifdef VERILAB_I2C_STRETCH_EN
      scl_en_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= '0;
      byte_done_q <= 1'b0;
      ack_drive_q <= 1'b0;
      first_q     <= 1'b0;
      rx_data_q   <= '0;
      rx_first_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      sda_en_q    <= 1'b0;
      overflow_q  <= 1'b0;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
`ifdef VERILAB_I2C_STRETCH_EN
      scl_en_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
      ack_drive_q <= ack_drive_d;
      first_q     <= first_d;
      rx_data_q   <= rx_data_d;
      rx_first_q  <= rx_first_d;
      rx_valid_q  <= rx_valid_d;
      sda_en_q    <= sda_en_d;
      overflow_q  <= overflow_d;
      scl_prev_q  <= scl_f;
      sda_prev_q  <= sda_f;
`ifdef VERILAB_I2C_STRETCH_EN
      scl_en_q    <= scl_en_d;
`endif
    end
  end

  assign core_i2c_scl_out = 1'b0;
  assign core_i2c_sda_out = 1'b0;
  assign core_i2c_sda_en  = sda_en_q;
`ifdef VERILAB_I2C_STRETCH_EN
  assign core_i2c_scl_en  = scl_en_q;
`else
  assign core_i2c_scl_en  = 1'b0;
`endif
  assign rx_data   = rx_data_q;
  assign rx_first  = rx_first_q;
  assign rx_valid  = rx_valid_q;
  assign overflow  = overflow_q;
  assign start_det = start_ev;
  assign stop_det  = stop_ev;

endmodule

// File: tb/tb_verilab_i2c_target_rx.sv
module tb_verilab_i2c_target_rx;
  import verilab_i2c_pkg::*;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m_scl = 1'b1, m_sda = 1'b1;
  logic rx_ready = 1'b0;
  logic scl_line, sda_line;
  logic core_i2c_scl_out, core_i2c_scl_en, core_i2c_sda_out, core_i2c_sda_en;
  logic [7:0] rx_data;
  logic rx_first, rx_valid, start_det, stop_det, overflow;

  // open-drain bus: either side may pull low
  assign scl_line = m_scl & ~core_i2c_scl_en;
  assign sda_line = m_sda & ~core_i2c_sda_en;

  always #5 clk = ~clk;

  verilab_i2c_target_rx dut (
    .clk(clk), .reset(reset),
    .core_i2c_scl_in(scl_line), .core_i2c_sda_in(sda_line),
    .core_i2c_scl_out(core_i2c_scl_out), .core_i2c_scl_en(core_i2c_scl_en),
    .core_i2c_sda_out(core_i2c_sda_out), .core_i2c_sda_en(core_i2c_sda_en),
    .rx_data(rx_data), .rx_first(rx_first), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .start_det(start_det), .stop_det(stop_det), .overflow(overflow));

  int n_pass = 0, n_tot = 0;
  int n_start = 0, n_stop = 0, n_ovf = 0, n_sda = 0, n_scl = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Monitor away from the active edge
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (start_det) n_start++;
      if (stop_det) n_stop++;
      if (overflow) n_ovf++;
      if (core_i2c_sda_en) n_sda++;
      if (core_i2c_scl_en) n_scl++;
      if (rx_valid && rx_ready) got_q.push_back({rx_data, rx_first});
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scl_high();
    int n = 0;
    m_scl = 1'b1;
    while (!scl_line && n < 5000) begin wclk(1); n++; end
    if (n > 0) chk("scl_release", 32'(scl_line), 32'd1);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wclk(Q);
    scl_high(); wclk(Q);
    m_sda = 1'b0; wclk(Q);
    m_scl = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wclk(Q);
    scl_high(); wclk(Q);
    m_sda = 1'b1; wclk(Q);
  endtask

  task automatic write_bits(input logic [7:0] b, input int glitch_bit);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; wclk(Q);
      if (i == glitch_bit) begin
        m_scl = 1'b1; wclk(2);   // shorter than FILTER_LEN
        m_scl = 1'b0; wclk(Q);
      end
      scl_high(); wclk(2 * Q);
      m_scl = 1'b0; wclk(Q);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    write_bits(b, glitch_bit);
    m_sda = 1'b1; wclk(Q);
    scl_high(); wclk(Q);
    ack = ~sda_line;
    wclk(Q);
    m_scl = 1'b0; wclk(Q);
  endtask

  // mode 0: rx_ready held 1; 1: held 0 then drained after STOP;
  // 2: held 0 until the target stretches SCL, then raised
  task automatic run_txn(input logic [7:0] addr, input int nd, input logic [2:0][7:0] d,
                         input int mode, output logic [3:0] acks);
    logic a;
    acks = 4'b0;
    rx_ready = (mode == 0);
    if (mode == 2) begin
      fork begin
        int n = 0;
        while (!core_i2c_scl_en && n < 5000) begin wclk(1); n++; end
        wclk(50);
        rx_ready = 1'b1;
      end join_none
    end
    i2c_start();
    write_byte(addr, -1, a); acks[0] = a;
    for (int i = 0; i < nd; i++) begin
      write_byte(d[i], -1, a); acks[i+1] = a;
    end
    i2c_stop();
    if (mode == 1) begin
      wclk(2); rx_ready = 1'b1; wclk(1); rx_ready = 1'b0;
    end
    wclk(4);
  endtask

  task automatic check_got(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  // Reference: what a write-only target with a one-entry buffer should do.
  task automatic model(input logic [7:0] addr, input int nd, input logic [2:0][7:0] d,
                       input bit rdy, output logic [3:0] acks, output int ovf);
    bit match, full, first;
    acks = 4'b0; ovf = 0; exp_q.delete();
    match = (addr[7:1] == 7'h42) && (addr[0] == 1'b0);
    full = 1'b0; first = 1'b1;
    acks[0] = match;
    for (int i = 0; i < nd; i++) begin
      if (match) begin
        if (!full) begin
          exp_q.push_back({d[i], first});
          first = 1'b0;
          acks[i+1] = 1'b1;
          if (!rdy) full = 1'b1;
        end else ovf++;
      end
    end
  endtask

  typedef struct {
    logic [7:0]      addr;
    int              nd;
    logic [2:0][7:0] d;
    int              mode;
    logic [3:0]      exp_ack;
    int              exp_ngot;
    logic [2:0][7:0] exp_d;
    logic [2:0]      exp_f;
    int              exp_ovf;
    bit              exp_drv;
    bit              exp_str;
  } vec_t;

  localparam int NV = 6;
  vec_t tbl[NV];

  task automatic set_vec(input int i, input logic [7:0] addr, input int nd,
                         input logic [7:0] d0, d1, d2, input int mode, input logic [3:0] ack,
                         input int ngot, input logic [7:0] e0, e1, e2, input logic [2:0] f,
                         input int ovf, input bit drv, input bit str);
    tbl[i].addr = addr; tbl[i].nd = nd; tbl[i].d = {d2, d1, d0}; tbl[i].mode = mode;
    tbl[i].exp_ack = ack; tbl[i].exp_ngot = ngot; tbl[i].exp_d = {e2, e1, e0};
    tbl[i].exp_f = f; tbl[i].exp_ovf = ovf; tbl[i].exp_drv = drv; tbl[i].exp_str = str;
  endtask

  initial begin
    logic [3:0] acks, eacks;
    logic a;
    int s0, p0, o0, d0, c0, eovf, nd;
    logic [7:0] addr;
    logic [2:0][7:0] d;
    bit rdy;

    set_vec(0, 8'h84, 2, 8'hA5, 8'h3C, 8'h00, 0, 4'b0111, 2, 8'hA5, 8'h3C, 8'h00, 3'b001, 0, 1, 0);
    set_vec(1, 8'h86, 1, 8'h5A, 8'h00, 8'h00, 0, 4'b0000, 0, 8'h00, 8'h00, 8'h00, 3'b000, 0, 0, 0);
    set_vec(2, 8'h85, 1, 8'h5A, 8'h00, 8'h00, 0, 4'b0000, 0, 8'h00, 8'h00, 8'h00, 3'b000, 0, 0, 0);
`ifdef VERILAB_I2C_STRETCH_EN
    set_vec(3, 8'h84, 2, 8'h11, 8'h22, 8'h00, 2, 4'b0111, 2, 8'h11, 8'h22, 8'h00, 3'b001, 0, 1, 1);
`else
    set_vec(3, 8'h84, 2, 8'h11, 8'h22, 8'h00, 1, 4'b0011, 1, 8'h11, 8'h00, 8'h00, 3'b001, 1, 1, 0);
`endif
    set_vec(4, 8'h84, 3, 8'h00, 8'h80, 8'h01, 0, 4'b1111, 3, 8'h00, 8'h80, 8'h01, 3'b001, 0, 1, 0);
    set_vec(5, 8'h84, 1, 8'hFF, 8'h00, 8'h00, 1, 4'b0011, 1, 8'hFF, 8'h00, 8'h00, 3'b001, 0, 1, 0);

    // reset state
    wclk(5);
    chk("rst_sda_en", 32'(core_i2c_sda_en), 0);
    chk("rst_scl_en", 32'(core_i2c_scl_en), 0);
    chk("rst_outs", 32'({core_i2c_scl_out, core_i2c_sda_out, rx_valid, rx_first,
                         start_det, stop_det, overflow}), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    reset = 1'b0;
    wclk(5);

    // table-driven transactions
    for (int v = 0; v < NV; v++) begin
      s0 = n_start; p0 = n_stop; o0 = n_ovf; d0 = n_sda; c0 = n_scl; got_q.delete();
      run_txn(tbl[v].addr, tbl[v].nd, tbl[v].d, tbl[v].mode, acks);
      for (int k = 0; k <= tbl[v].nd; k++)
        chk($sformatf("vec%0d_ack%0d", v, k), 32'(acks[k]), 32'(tbl[v].exp_ack[k]));
      exp_q.delete();
      for (int k = 0; k < tbl[v].exp_ngot; k++) exp_q.push_back({tbl[v].exp_d[k], tbl[v].exp_f[k]});
      check_got($sformatf("vec%0d_rx", v));
      chk($sformatf("vec%0d_ovf", v), 32'(n_ovf - o0), 32'(tbl[v].exp_ovf));
      chk($sformatf("vec%0d_start", v), 32'(n_start - s0), 1);
      chk($sformatf("vec%0d_stop", v), 32'(n_stop - p0), 1);
      chk($sformatf("vec%0d_sda_drv", v), 32'(n_sda > d0), 32'(tbl[v].exp_drv));
      chk($sformatf("vec%0d_stretch", v), 32'(n_scl > c0), 32'(tbl[v].exp_str));
    end

    // repeated START after the first data byte
    s0 = n_start; p0 = n_stop; got_q.delete(); rx_ready = 1'b1;
    i2c_start();
    write_byte(8'h84, -1, a); write_byte(8'h55, -1, a);
    i2c_start();
    write_byte(8'h84, -1, a); write_byte(8'h77, -1, a);
    chk("rs_ack", 32'(a), 1);
    i2c_stop(); wclk(4);
    exp_q.delete(); exp_q.push_back({8'h55, 1'b1}); exp_q.push_back({8'h77, 1'b1});
    check_got("rs_rx");
    chk("rs_start", 32'(n_start - s0), 2);
    chk("rs_stop", 32'(n_stop - p0), 1);

    // SCL glitch during a data bit
    got_q.delete();
    i2c_start();
    write_byte(8'h84, -1, a); write_byte(8'hC3, 4, a);
    chk("glitch_ack", 32'(a), 1);
    i2c_stop(); wclk(4);
    exp_q.delete(); exp_q.push_back({8'hC3, 1'b1});
    check_got("glitch_rx");

    // reset asserted during a data ACK slot
    got_q.delete(); rx_ready = 1'b0;
    i2c_start();
    write_byte(8'h84, -1, a);
    write_bits(8'hA5, -1);
    m_sda = 1'b1;
    begin
      int n = 0;
      while (!core_i2c_sda_en && n < 50) begin wclk(1); n++; end
    end
    chk("rst_ack_driven", 32'(core_i2c_sda_en), 1);
    reset = 1'b1; wclk(1);
    chk("rst_mid_sda_en", 32'(core_i2c_sda_en), 0);
    chk("rst_mid_valid", 32'(rx_valid), 0);
    chk("rst_mid_state", 32'(dut.state_q), 32'(ST_IDLE));
    m_scl = 1'b1; m_sda = 1'b1; wclk(Q);
    reset = 1'b0; wclk(2 * Q);
    chk("rst_after_valid", 32'(rx_valid), 0);
    chk("rst_after_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rst_after_rx", 32'(got_q.size()), 0);

    // randomized transactions against the reference model
    for (int t = 0; t < 20; t++) begin
      addr = ($urandom_range(2) == 0) ? 8'($urandom_range(255)) : 8'h84;
      nd = int'($urandom_range(1, 3));
      for (int k = 0; k < 3; k++) d[k] = 8'($urandom_range(255));
`ifdef VERILAB_I2C_STRETCH_EN
      rdy = 1'b1;
`else
      rdy = ($urandom_range(1) == 1);
`endif
      model(addr, nd, d, rdy, eacks, eovf);
      s0 = n_start; p0 = n_stop; o0 = n_ovf; got_q.delete();
      run_txn(addr, nd, d, rdy ? 0 : 1, acks);
      for (int k = 0; k <= nd; k++)
        chk($sformatf("rnd%0d_ack%0d", t, k), 32'(acks[k]), 32'(eacks[k]));
      check_got($sformatf("rnd%0d_rx", t));
      chk($sformatf("rnd%0d_ovf", t), 32'(n_ovf - o0), 32'(eovf));
      chk($sformatf("rnd%0d_start", t), 32'(n_start - s0), 1);
      chk($sformatf("rnd%0d_stop", t), 32'(n_stop - p0), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
